// File: rtl/count_match_irq.sv
// Compare stage behind the free-running counter: raises a held interrupt on each
// armed rising edge of (count_in == target), counts captured matches and flags lost ones.
module count_match_irq #(
  parameter int N     = 7,
  parameter int EVT_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N:0]       count_in,
  input  logic             load,
  input  logic [N:0]       target_in,
  input  logic             arm,
  input  logic             ack,
  output logic             irq,
  output logic             armed,
  output logic [N:0]       target,
  output logic [EVT_W-1:0] match_cnt,
  output logic             missed
);

  // Handshake: irq is a level that stays high until ack is sampled high at a
  // rising edge while FIRED; ack and arm outside their states are ignored.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

  localparam logic [EVT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic             eq;
  logic             eq_d;
  logic             match_evt;
  logic [N:0]       target_nxt;
  logic [EVT_W-1:0] cnt_nxt;
  logic             missed_nxt;

  // A held count must produce only one event, so only the rising edge of equality counts.
  assign eq        = (count_in == target);
  assign match_evt = eq & ~eq_d;

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    cnt_nxt    = match_cnt;
    missed_nxt = missed;
    case (state)
      IDLE: begin
        if (load) target_nxt = target_in;
        if (arm)  state_nxt  = ARMED;
      end
      ARMED: begin
        if (match_evt) begin
          state_nxt = FIRED;
          if (match_cnt != CNT_MAX) cnt_nxt = match_cnt + 1'b1;
        end
      end
      FIRED: begin
        if (match_evt) missed_nxt = 1'b1;
        if (ack)       state_nxt  = arm ? ARMED : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      eq_d      <= 1'b0;
      target    <= '0;
      match_cnt <= '0;
      missed    <= 1'b0;
      irq       <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      eq_d      <= eq;
      target    <= target_nxt;
      match_cnt <= cnt_nxt;
      missed    <= missed_nxt;
      irq       <= (state_nxt == FIRED);
      armed     <= (state_nxt == ARMED);
    end
  end

endmodule

// File: tb/tb_count_match_irq.sv
// Randomized and directed bench for count_match_irq with a behavioural model;
// a second instance with EVT_W=2 exercises match-counter saturation.
module tb_count_match_irq;

  logic       clock;
  logic       clear;
  logic [7:0] count_in;
  logic       load;
  logic [7:0] target_in;
  logic       arm;
  logic       ack;

  logic       irq, armed, missed;
  logic [7:0] target;
  logic [3:0] match_cnt;
  logic       irq2, armed2, missed2;
  logic [7:0] target2;
  logic [1:0] match_cnt2;

  int total = 0;
  int bad   = 0;

  // model: 0 idle, 1 waiting for match, 2 interrupt pending
  int         m_mode;
  logic [7:0] m_target;
  int         m_prev_eq;
  int         m_events;
  int         m_missed;
  logic [7:0] cnt_v;

  count_match_irq #(.N(7), .EVT_W(4)) dut (
    .clock(clock), .clear(clear), .count_in(count_in), .load(load),
    .target_in(target_in), .arm(arm), .ack(ack), .irq(irq), .armed(armed),
    .target(target), .match_cnt(match_cnt), .missed(missed)
  );

  count_match_irq #(.N(7), .EVT_W(2)) dut_w2 (
    .clock(clock), .clear(clear), .count_in(count_in), .load(load),
    .target_in(target_in), .arm(arm), .ack(ack), .irq(irq2), .armed(armed2),
    .target(target2), .match_cnt(match_cnt2), .missed(missed2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_update();
    int is_eq;
    int rise;
    is_eq = (count_in == m_target) ? 1 : 0;
    rise  = is_eq & (1 - m_prev_eq);
    if (clear) begin
      m_mode = 0; m_target = '0; m_prev_eq = 0; m_events = 0; m_missed = 0;
    end else begin
      if (m_mode == 0) begin
        if (load) m_target = target_in;
        if (arm)  m_mode = 1;
      end else if (m_mode == 1) begin
        if (rise == 1) begin
          m_mode = 2;
          m_events++;
        end
      end else begin
        if (rise == 1) m_missed = 1;
        if (ack) m_mode = arm ? 1 : 0;
      end
      m_prev_eq = is_eq;
    end
  endtask

  task automatic compare_all();
    chk("irq",        irq,        m_mode == 2);
    chk("armed",      armed,      m_mode == 1);
    chk("target",     target,     m_target);
    chk("match_cnt",  match_cnt,  sat(m_events, 15));
    chk("missed",     missed,     m_missed);
    chk("irq_w2",     irq2,       m_mode == 2);
    chk("armed_w2",   armed2,     m_mode == 1);
    chk("target_w2",  target2,    m_target);
    chk("match_cnt_w2", match_cnt2, sat(m_events, 3));
    chk("missed_w2",  missed2,    m_missed);
  endtask

  // One cycle: drive on the falling edge, update the model at the rising edge, compare just after.
  task automatic step(input logic c, input logic l, input logic a, input logic k,
                      input logic [7:0] ti, input logic [7:0] ci);
    @(negedge clock);
    clear = c; load = l; arm = a; ack = k; target_in = ti; count_in = ci;
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cnt_v = cnt_v + 8'd1;
      step(0, 0, 0, 0, 8'd0, cnt_v);
    end
  endtask

  initial begin
    clear = 1'b1; load = 1'b0; arm = 1'b0; ack = 1'b0;
    target_in = '0; count_in = '0; cnt_v = '0;
    m_mode = 0; m_target = '0; m_prev_eq = 0; m_events = 0; m_missed = 0;

    // reset, then load 5 and arm together
    step(1, 0, 0, 0, 8'd0, 8'd0);
    step(1, 0, 0, 0, 8'd0, 8'd0);
    chk("lit_reset_irq", irq, 0);
    chk("lit_reset_cnt", match_cnt, 0);
    step(0, 1, 1, 0, 8'd5, 8'd0);
    chk("lit_armed", armed, 1);
    chk("lit_target5", target, 5);
    run(5);
    chk("lit_fire_irq", irq, 1);
    chk("lit_fire_cnt", match_cnt, 1);
    chk("lit_fire_armed", armed, 0);

    // full wrap without ack: match lost
    run(256);
    chk("lit_wrap_irq", irq, 1);
    chk("lit_wrap_cnt", match_cnt, 1);
    chk("lit_wrap_missed", missed, 1);
    cnt_v = cnt_v + 8'd1;
    step(0, 0, 0, 1, 8'd0, cnt_v);
    chk("lit_ack_irq", irq, 0);
    chk("lit_ack_idle", armed, 0);

    // target 3, then ack+arm re-arms directly
    cnt_v = cnt_v + 8'd1;
    step(0, 1, 1, 0, 8'd3, cnt_v);
    run(252);
    chk("lit_t3_count", count_in, 3);
    chk("lit_t3_irq", irq, 1);
    chk("lit_t3_cnt", match_cnt, 2);
    step(0, 0, 1, 1, 8'd0, 8'd4);
    chk("lit_rearm_armed", armed, 1);
    chk("lit_rearm_irq", irq, 0);
    cnt_v = 8'd4;
    run(255);
    chk("lit_t3b_irq", irq, 1);
    chk("lit_t3b_cnt", match_cnt, 3);

    // load ignored in FIRED, clear overrides FIRED, load ignored in ARMED
    step(0, 1, 0, 0, 8'd9, 8'd4);
    chk("lit_load_fired", target, 3);
    step(1, 0, 1, 1, 8'd9, 8'd5);
    chk("lit_clr_irq", irq, 0);
    chk("lit_clr_armed", armed, 0);
    chk("lit_clr_missed", missed, 0);
    chk("lit_clr_cnt", match_cnt, 0);
    chk("lit_clr_target", target, 0);
    step(0, 0, 1, 0, 8'd0, 8'd6);
    step(0, 1, 0, 0, 8'd9, 8'd7);
    chk("lit_load_armed", target, 0);
    step(1, 0, 0, 0, 8'd0, 8'd1);

    // counter held at 0 with target 0: exactly one event
    step(0, 0, 1, 0, 8'd0, 8'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 8'd0, 8'd0);
    chk("lit_hold_irq", irq, 1);
    chk("lit_hold_cnt", match_cnt, 1);
    step(0, 0, 1, 1, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'd0, 8'd0);
    chk("lit_hold_nofire", irq, 0);
    cnt_v = 8'd0;
    run(256);
    chk("lit_hold_refire", irq, 1);
    chk("lit_hold_cnt2", match_cnt, 2);

    // saturation on the 2-bit instance: 1,2,3,3,3
    step(1, 0, 0, 0, 8'd0, 8'd1);
    step(0, 1, 1, 0, 8'd2, 8'd1);
    cnt_v = 8'd1;
    for (int i = 0; i < 5; i++) begin
      do begin
        cnt_v = cnt_v + 8'd1;
        step(0, 0, 0, 0, 8'd0, cnt_v);
      end while (cnt_v != 8'd2);
      chk("lit_sat_w2", match_cnt2, (i < 2) ? i + 1 : 3);
      cnt_v = cnt_v + 8'd1;
      step(0, 0, 1, 1, 8'd0, cnt_v);
    end
    chk("lit_sat_w4", match_cnt, 5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 80)      cnt_v = cnt_v + 8'd1;
      else if (r < 90) cnt_v = cnt_v;
      else             cnt_v = 8'($urandom_range(0, 255));
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0,
           8'($urandom_range(0, 255)),
           cnt_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
